// File: rtl/shiftleds_pkg.sv
// Shared encodings for the multimode shift-LED block.
// Mode, colour and ping-pong direction types plus default sizes.
package shiftleds_pkg;

  localparam int NB_LEDS_DEF  = 4;
  localparam int NB_COUNT_DEF = 14;

  typedef enum logic [1:0] {
    MODE_ROTATE   = 2'b00,
    MODE_PINGPONG = 2'b01,
    MODE_FLASH    = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    COLOR_R   = 2'b00,
    COLOR_G   = 2'b01,
    COLOR_B   = 2'b10,
    COLOR_OFF = 2'b11
  } color_e;

  typedef enum logic {
    PP_UP   = 1'b0,
    PP_DOWN = 1'b1
  } pp_dir_e;

endpackage

// File: rtl/shiftleds_multimode_if.sv
// Switch-side controls and LED-side outputs of the shift-LED block.
// master drives the switches, slave is the LED engine.
interface shiftleds_multimode_if #(
  parameter int NB_LEDS = 4
);

  logic               i_enable;
  logic [1:0]         i_sel_limit;
  logic [1:0]         i_mode;
  logic               i_dir;
  logic [1:0]         i_color;
  logic [NB_LEDS-1:0] o_led;
  logic [NB_LEDS-1:0] o_led_r;
  logic [NB_LEDS-1:0] o_led_g;
  logic [NB_LEDS-1:0] o_led_b;
  logic               o_tick;

  modport master (
    output i_enable,
    output i_sel_limit,
    output i_mode,
    output i_dir,
    output i_color,
    input  o_led,
    input  o_led_r,
    input  o_led_g,
    input  o_led_b,
    input  o_tick
  );

  modport slave (
    input  i_enable,
    input  i_sel_limit,
    input  i_mode,
    input  i_dir,
    input  i_color,
    output o_led,
    output o_led_r,
    output o_led_g,
    output o_led_b,
    output o_tick
  );

endinterface

// File: rtl/shiftleds_prescaler.sv
// Free-running prescaler with four selectable wrap limits.
// tick is high on the last count of each period.
module shiftleds_prescaler
  import shiftleds_pkg::*;
#(
  parameter int NB_COUNT = NB_COUNT_DEF,
  parameter int LIMIT_0  = 1023,
  parameter int LIMIT_1  = 2047,
  parameter int LIMIT_2  = 4095,
  parameter int LIMIT_3  = 8191
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic       enable,
  input  logic [1:0] sel_limit,
  output logic       tick
);

  localparam logic [NB_COUNT-1:0] LIM0 = NB_COUNT'(LIMIT_0);
  localparam logic [NB_COUNT-1:0] LIM1 = NB_COUNT'(LIMIT_1);
  localparam logic [NB_COUNT-1:0] LIM2 = NB_COUNT'(LIMIT_2);
  localparam logic [NB_COUNT-1:0] LIM3 = NB_COUNT'(LIMIT_3);

  logic [NB_COUNT-1:0] counter;
  logic [NB_COUNT-1:0] limit;

  // Limit mux; >= lets a lowered limit force an immediate wrap.
  always_comb begin
    limit = LIM0;
    unique case (sel_limit)
      2'd0: limit = LIM0;
      2'd1: limit = LIM1;
      2'd2: limit = LIM2;
      2'd3: limit = LIM3;
    endcase
  end

  assign tick = enable && (counter >= limit);

  // Count while enabled, clear on wrap.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      counter <= '0;
    end else if (enable) begin
      counter <= tick ? '0 : counter + NB_COUNT'(1);
    end
  end

endmodule

// File: rtl/shiftleds_multimode.sv
// Multimode shift-LED engine: rotate, ping-pong, flash, hold.
// Pattern advances on prescaler ticks and is routed to one colour.
module shiftleds_multimode
  import shiftleds_pkg::*;
#(
  parameter int NB_LEDS  = NB_LEDS_DEF,
  parameter int NB_COUNT = NB_COUNT_DEF,
  parameter int LIMIT_0  = 1023,
  parameter int LIMIT_1  = 2047,
  parameter int LIMIT_2  = 4095,
  parameter int LIMIT_3  = 8191
) (
  input  logic clock,
  input  logic i_reset,
  shiftleds_multimode_if.slave bus
);

  localparam logic [NB_LEDS-1:0] PAT_ONE =
    {{(NB_LEDS-1){1'b0}}, 1'b1};

  logic               tick;
  logic [NB_LEDS-1:0] pattern;
  logic [NB_LEDS-1:0] pattern_nxt;
  pp_dir_e            pp_dir;
  pp_dir_e            pp_dir_nxt;
  logic               one_hot;
  mode_e              mode;
  logic [NB_LEDS-1:0] led_r;
  logic [NB_LEDS-1:0] led_g;
  logic [NB_LEDS-1:0] led_b;

  shiftleds_prescaler #(
    .NB_COUNT (NB_COUNT),
    .LIMIT_0  (LIMIT_0),
    .LIMIT_1  (LIMIT_1),
    .LIMIT_2  (LIMIT_2),
    .LIMIT_3  (LIMIT_3)
  ) u_prescaler (
    .clock     (clock),
    .i_reset   (i_reset),
    .enable    (bus.i_enable),
    .sel_limit (bus.i_sel_limit),
    .tick      (tick)
  );

  assign mode    = mode_e'(bus.i_mode);
  assign one_hot = (pattern != '0) &&
                   ((pattern & (pattern - PAT_ONE)) == '0);

  // Pattern state register, advanced only by the tick.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      pattern <= PAT_ONE;
      pp_dir  <= PP_UP;
    end else begin
      pattern <= pattern_nxt;
      pp_dir  <= pp_dir_nxt;
    end
  end

  // Next pattern; shifting modes first recover a one-hot value.
  always_comb begin
    pattern_nxt = pattern;
    pp_dir_nxt  = pp_dir;
    if (tick) begin
      unique case (mode)
        MODE_ROTATE: begin
          if (!one_hot) begin
            pattern_nxt = PAT_ONE;
            pp_dir_nxt  = PP_UP;
          end else if (bus.i_dir) begin
            pattern_nxt = {pattern[0], pattern[NB_LEDS-1:1]};
          end else begin
            pattern_nxt = {pattern[NB_LEDS-2:0], pattern[NB_LEDS-1]};
          end
        end
        MODE_PINGPONG: begin
          if (!one_hot) begin
            pattern_nxt = PAT_ONE;
            pp_dir_nxt  = PP_UP;
          end else if (pp_dir == PP_UP && pattern[NB_LEDS-1]) begin
            pp_dir_nxt  = PP_DOWN;
            pattern_nxt = pattern >> 1;
          end else if (pp_dir == PP_DOWN && pattern[0]) begin
            pp_dir_nxt  = PP_UP;
            pattern_nxt = pattern << 1;
          end else if (pp_dir == PP_UP) begin
            pattern_nxt = pattern << 1;
          end else begin
            pattern_nxt = pattern >> 1;
          end
        end
        MODE_FLASH: begin
          pattern_nxt = (&pattern) ? '0 : '1;
        end
        MODE_HOLD: begin
          pattern_nxt = pattern;
        end
      endcase
    end
  end

  // Colour routing, registered every clock regardless of enable.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      led_r <= '0;
      led_g <= '0;
      led_b <= '0;
    end else begin
      led_r <= (bus.i_color == COLOR_R) ? pattern : '0;
      led_g <= (bus.i_color == COLOR_G) ? pattern : '0;
      led_b <= (bus.i_color == COLOR_B) ? pattern : '0;
    end
  end

  assign bus.o_led   = pattern;
  assign bus.o_led_r = led_r;
  assign bus.o_led_g = led_g;
  assign bus.o_led_b = led_b;
  assign bus.o_tick  = tick;

endmodule

// File: tb/tb_shiftleds_multimode.sv
// Bench for shiftleds_multimode with a small prescaler.
// Vector table, hand corner sequences and random run vs a model.
module tb_shiftleds_multimode;

  logic clock = 1'b0;
  logic i_reset;

  always #5 clock = ~clock;

  shiftleds_multimode_if #(.NB_LEDS(4)) bus ();

  shiftleds_multimode #(
    .NB_LEDS  (4),
    .NB_COUNT (4),
    .LIMIT_0  (1),
    .LIMIT_1  (3),
    .LIMIT_2  (7),
    .LIMIT_3  (15)
  ) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  typedef struct {
    bit en;
    int sel;
    int mode;
    int dir;
    int color;
    int led;
    int tick;
  } vec_t;

  int total = 0;
  int bad   = 0;

  int m_cnt;
  int m_pat;
  bit m_up;
  int m_r;
  int m_g;
  int m_b;
  bit last_tick;

  function automatic int lim_of(int sel);
    return (2 << sel) - 1;
  endfunction

  function automatic bit m_tick();
    return bus.i_enable && (m_cnt >= lim_of(int'(bus.i_sel_limit)));
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_pat = 1;
    m_up  = 1'b1;
    m_r   = 0;
    m_g   = 0;
    m_b   = 0;
  endtask

  task automatic model_edge();
    bit t;
    int c;
    int md;
    t  = m_tick();
    c  = int'(bus.i_color);
    md = int'(bus.i_mode);
    m_r = (c == 0) ? m_pat : 0;
    m_g = (c == 1) ? m_pat : 0;
    m_b = (c == 2) ? m_pat : 0;
    if (bus.i_enable) m_cnt = t ? 0 : m_cnt + 1;
    if (t) begin
      if ((md == 0 || md == 1) && $countones(m_pat) != 1) begin
        m_pat = 1;
        m_up  = 1'b1;
      end else if (md == 0) begin
        if (bus.i_dir) m_pat = (m_pat == 1) ? 8 : m_pat / 2;
        else           m_pat = (m_pat == 8) ? 1 : m_pat * 2;
      end else if (md == 1) begin
        if (m_up) begin
          if (m_pat == 8) begin
            m_up  = 1'b0;
            m_pat = 4;
          end else begin
            m_pat = m_pat * 2;
          end
        end else begin
          if (m_pat == 1) begin
            m_up  = 1'b1;
            m_pat = 2;
          end else begin
            m_pat = m_pat / 2;
          end
        end
      end else if (md == 2) begin
        m_pat = (m_pat == 15) ? 0 : 15;
      end
    end
  endtask

  task automatic drive(bit en, int sel, int mode, int dir, int color);
    bus.i_enable    = en;
    bus.i_sel_limit = 2'(sel);
    bus.i_mode      = 2'(mode);
    bus.i_dir       = dir[0];
    bus.i_color     = 2'(color);
  endtask

  task automatic step();
    #1;
    chk("led", int'(bus.o_led), m_pat);
    chk("tick", int'(bus.o_tick), int'(m_tick()));
    chk("red", int'(bus.o_led_r), m_r);
    chk("green", int'(bus.o_led_g), m_g);
    chk("blue", int'(bus.o_led_b), m_b);
    chk("counter", int'(dut.u_prescaler.counter), m_cnt);
    last_tick = bus.o_tick;
    if (i_reset) model_edge();
    @(negedge clock);
  endtask

  task automatic run_to_tick();
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_tick) return;
    end
    chk("tick_timeout", 0, 1);
  endtask

  task automatic do_reset();
    #2;
    i_reset = 1'b0;
    #1;
    model_reset();
    @(negedge clock);
    i_reset = 1'b1;
  endtask

  vec_t tbl[14];
  int   pp_exp[7];
  int   prev;
  int   gap;

  initial begin
    i_reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    @(negedge clock);
    step();
    step();
    i_reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      tbl[i].en    = 1'b1;
      tbl[i].sel   = 0;
      tbl[i].mode  = 0;
      tbl[i].dir   = (i >= 9) ? 1 : 0;
      tbl[i].color = 0;
      tbl[i].tick  = i % 2;
    end
    tbl[0].led  = 1; tbl[1].led  = 1;
    tbl[2].led  = 2; tbl[3].led  = 2;
    tbl[4].led  = 4; tbl[5].led  = 4;
    tbl[6].led  = 8; tbl[7].led  = 8;
    tbl[8].led  = 1; tbl[9].led  = 1;
    tbl[10].led = 8; tbl[11].led = 8;
    tbl[12].led = 4; tbl[13].led = 4;

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].en, tbl[i].sel, tbl[i].mode, tbl[i].dir, tbl[i].color);
      #1;
      chk("vec_led", int'(bus.o_led), tbl[i].led);
      chk("vec_tick", int'(bus.o_tick), tbl[i].tick);
      step();
    end

    drive(1, 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (m_cnt == 1) break;
      step();
    end
    prev = int'(bus.o_led);
    drive(0, 1, 0, 0, 0);
    repeat (5) step();
    #1;
    chk("gate_counter", int'(dut.u_prescaler.counter), 1);
    chk("gate_led", int'(bus.o_led), prev);
    chk("gate_tick", int'(bus.o_tick), 0);
    @(negedge clock);
    drive(1, 1, 0, 0, 0);
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      gap++;
      step();
      if (last_tick) break;
    end
    chk("retick_gap", gap, 3);

    do_reset();
    pp_exp = '{2, 4, 8, 4, 2, 1, 2};
    for (int k = 0; k < 7; k++) begin
      drive(1, 0, 1, k % 2, 0);
      run_to_tick();
      chk("pingpong", int'(bus.o_led), pp_exp[k]);
    end

    do_reset();
    drive(1, 0, 0, 0, 1);
    run_to_tick();
    run_to_tick();
    chk("pre_flash", int'(bus.o_led), 4);
    drive(1, 0, 2, 0, 1);
    run_to_tick();
    chk("flash1", int'(bus.o_led), 15);
    run_to_tick();
    chk("flash2", int'(bus.o_led), 0);
    run_to_tick();
    chk("flash3", int'(bus.o_led), 15);
    drive(1, 0, 0, 0, 1);
    run_to_tick();
    chk("normalise", int'(bus.o_led), 1);
    run_to_tick();
    chk("after_norm", int'(bus.o_led), 2);

    drive(1, 3, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      if (m_cnt == 10) break;
      step();
    end
    chk("lim_pre_counter", int'(dut.u_prescaler.counter), 10);
    drive(1, 0, 0, 0, 0);
    #1;
    chk("lim_tick", int'(bus.o_tick), 1);
    step();
    chk("lim_counter", int'(dut.u_prescaler.counter), 0);
    chk("lim_led", int'(bus.o_led), 4);

    drive(1, 0, 0, 0, 2);
    for (int i = 0; i < 8; i++) begin
      prev = int'(bus.o_led);
      step();
      chk("blue_delay", int'(bus.o_led_b), prev);
      chk("blue_r0", int'(bus.o_led_r), 0);
      chk("blue_g0", int'(bus.o_led_g), 0);
    end
    drive(1, 0, 0, 0, 3);
    step();
    chk("off_r", int'(bus.o_led_r), 0);
    chk("off_g", int'(bus.o_led_g), 0);
    chk("off_b", int'(bus.o_led_b), 0);
    drive(1, 0, 0, 0, 2);
    while (m_pat == 1) step();
    step();
    #2;
    i_reset = 1'b0;
    #1;
    chk("arst_led", int'(bus.o_led), 1);
    chk("arst_r", int'(bus.o_led_r), 0);
    chk("arst_g", int'(bus.o_led_g), 0);
    chk("arst_b", int'(bus.o_led_b), 0);
    chk("arst_tick", int'(bus.o_tick), 0);
    chk("arst_counter", int'(dut.u_prescaler.counter), 0);
    model_reset();
    @(negedge clock);
    step();
    i_reset = 1'b1;

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) != 0, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shiftleds_multimode.md
Name: shiftleds_multimode

Overview:
Parametrised successor to the switch-controlled shift-LED block. A prescaler counter wraps at one of four selectable limits and produces a tick. Each tick advances an NB_LEDS-wide pattern in one of four modes: rotate, ping-pong, flash or hold. The pattern is routed to a selectable RGB colour channel. It sits between the board switches and the LED pins in the lab top level.

Parameters:
NB_LEDS, 4, number of LEDs / pattern width; must be >= 2
NB_COUNT, 14, prescaler counter width
LIMIT_0, 1023, prescaler limit for i_sel_limit=0; must be < 2**NB_COUNT
LIMIT_1, 2047, limit for i_sel_limit=1
LIMIT_2, 4095, limit for i_sel_limit=2
LIMIT_3, 8191, limit for i_sel_limit=3

Ports:
clock  input  1  system clock, rising edge
i_reset  input  1  asynchronous, active-low reset
i_enable  input  1  1 = run; 0 = freeze counter and pattern
i_sel_limit  input  2  prescaler limit select
i_mode  input  2  00 rotate, 01 ping-pong, 10 flash, 11 hold
i_dir  input  1  rotate direction: 0 = toward MSB, 1 = toward LSB
i_color  input  2  00 red, 01 green, 10 blue, 11 all colour outputs off
o_led  output  NB_LEDS  current pattern (mono LEDs)
o_led_r  output  NB_LEDS  red channel
o_led_g  output  NB_LEDS  green channel
o_led_b  output  NB_LEDS  blue channel
o_tick  output  1  prescaler wrap strobe

Behaviour:
- Reset (i_reset=0, async):
  - counter=0, pattern=1 (bit 0 set), pp_dir=up.
  - o_led_r/g/b=0 and o_tick=0 immediately.
  - Everything holds while reset is low.
- Prescaler:
  - o_tick (combinational) = i_enable && (counter >= LIMIT[i_sel_limit]).
  - On a clock edge with i_enable=1: counter <= o_tick ? 0 : counter+1.
  - Period is LIMIT+1 cycles.
  - The >= compare means lowering the limit below the current count forces a wrap on the next enabled cycle.
  - i_enable=0: counter and pattern hold; o_tick=0.
- Pattern update happens only on a clock edge with o_tick=1. i_mode and i_dir are sampled at that edge.
  - Normalisation: in rotate or ping-pong, if the pattern is not one-hot (left over from flash), the next pattern is 1 and pp_dir=up. No shift occurs on that tick.
  - Rotate: circular shift by one. With i_dir=0 the MSB wraps to bit 0; with i_dir=1 bit 0 wraps to the MSB.
  - Ping-pong (i_dir ignored):
    - up with pattern[MSB]=1: pp_dir<=down, shift right.
    - down with pattern[0]=1: pp_dir<=up, shift left.
    - otherwise: shift in pp_dir.
    - Sequence for 4 LEDs: 0001,0010,0100,1000,0100,0010,0001,0010...
  - Flash: if pattern is all-ones, next=all-zeros; otherwise next=all-ones.
  - Hold: pattern unchanged; counter keeps running.
  - pp_dir changes only in ping-pong and on normalisation.
- Outputs:
  - o_led = pattern register, zero latency.
  - Colour outputs are registered every clock, independent of i_enable: o_led_x <= (i_color selects x) ? pattern : 0. This gives one cycle of latency relative to o_led.
  - i_color=11 drives all colour outputs to 0.
- Simultaneous events: a mode change and a limit change in the same cycle as a tick both apply at that tick. The limit change applies to the compare in the current cycle.
- Reset mid-operation: async clear of all state; resumes from pattern 1 after release.

Decomposition:
- Shared header/package shiftleds_pkg:
  - mode encodings MODE_ROTATE/MODE_PINGPONG/MODE_FLASH/MODE_HOLD.
  - colour encodings COLOR_R/G/B/OFF.
  - default NB_LEDS/NB_COUNT.
- One sub-module: shiftleds_prescaler (instance u_prescaler).
  - Contains the counter, limit mux and tick.
  - The counter register is named counter so the bench can probe u_prescaler.counter.
- The pattern FSM and colour routing stay in the top module.

Test Plan:
All scenarios use bench overrides NB_COUNT=4, LIMIT_0..3 = 1,3,7,15.
1. Reset then i_enable=1, sel=0, rotate, i_dir=0 -> o_led=0001 during reset; then 0010,0100,1000,0001 every 2 cycles; o_tick high every 2nd cycle; i_dir=1 reverses to 1000,0100,...
2. Enable gating: drop i_enable for 5 cycles at counter=1, sel=1 -> counter stays 1, o_led unchanged, o_tick=0; after re-enable the next tick arrives 3 cycles later.
3. Ping-pong from 0001, sel=0 -> 0010,0100,1000,0100,0010,0001,0010 at 2-cycle spacing; toggling i_dir has no effect.
4. Mode switching: at pattern 0100 select flash -> ticks give 1111,0000,1111; select rotate -> next tick 0001, following tick 0010.
5. Limit change: sel=3, let counter reach 10, switch to sel=0 -> o_tick=1 in the next cycle, counter wraps to 0, and the pattern advances once.
6. Colour and reset: i_color=10 -> o_led_b equals o_led delayed 1 cycle, o_led_r=o_led_g=0; i_color=11 -> all three 0; assert i_reset low between clock edges -> o_led=0001 and colour outputs 0 without waiting for a clock.
